// File: rtl/masked_extremum_scanner.sv
// Sequential masked max/min: scans NUM_INPUTS signed candidates, one per cycle,
// and returns the best active one with its index and the OR of all activations.
module masked_extremum_scanner #(
  parameter  int NUMBER_SIZE = 4,
  parameter  int NUM_INPUTS  = 8,
  localparam int INDEX_SIZE  = $clog2(NUM_INPUTS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_INPUTS*NUMBER_SIZE-1:0] numbers,
  input  logic [NUM_INPUTS-1:0]             activations,
  input  logic                              find_min,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [NUMBER_SIZE-1:0]     extremum,
  output logic [INDEX_SIZE-1:0]             extremum_index,
  output logic                              extremum_activation
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [INDEX_SIZE-1:0] LAST = INDEX_SIZE'(NUM_INPUTS - 1);

  state_t                               state;
  logic [INDEX_SIZE-1:0]                idx;
  logic [NUM_INPUTS-1:0][NUMBER_SIZE-1:0] num_r;
  logic [NUM_INPUTS-1:0]                act_r;
  logic                                 min_r;
  logic                                 best_active;
  logic signed [NUMBER_SIZE-1:0]        best_val;
  logic [INDEX_SIZE-1:0]                best_idx;
  logic                                 ext_act;

  logic signed [NUMBER_SIZE-1:0]        cand;
  logic                                 better;
  logic                                 update;

  // Strict comparison keeps the lower index on ties.
  always_comb begin
    cand   = num_r[idx];
    better = min_r ? (cand < best_val) : (cand > best_val);
    update = act_r[idx] && (!best_active || better);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      num_r       <= '0;
      act_r       <= '0;
      min_r       <= 1'b0;
      best_active <= 1'b0;
      best_val    <= '0;
      best_idx    <= '0;
      ext_act     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          num_r       <= numbers;
          act_r       <= activations;
          min_r       <= find_min;
          idx         <= '0;
          best_active <= 1'b0;
          best_val    <= '0;
          best_idx    <= '0;
          ext_act     <= 1'b0;
          state       <= SCAN;
        end
        SCAN: begin
          if (update) begin
            best_val    <= cand;
            best_idx    <= idx;
            best_active <= 1'b1;
          end
          if (idx == LAST) begin
            idx     <= '0;
            ext_act <= |act_r;
            state   <= DONE;
          end else begin
            idx <= idx + INDEX_SIZE'(1);
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready            = (state == IDLE);
  assign out_valid           = (state == DONE);
  assign extremum            = best_val;
  assign extremum_index      = best_idx;
  assign extremum_activation = ext_act;

endmodule

// File: tb/tb_masked_extremum_scanner.sv
// Directed bench for masked_extremum_scanner with NUM_INPUTS=4, NUMBER_SIZE=4.
module tb_masked_extremum_scanner;
  localparam int NS = 4;
  localparam int NI = 4;
  localparam int IS = $clog2(NI);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [NI*NS-1:0]   numbers = '0;
  logic [NI-1:0]      activations = '0;
  logic               find_min = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [NS-1:0] extremum;
  logic [IS-1:0]      extremum_index;
  logic               extremum_activation;

  int checks = 0;
  int errors = 0;

  masked_extremum_scanner #(.NUMBER_SIZE(NS), .NUM_INPUTS(NI)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .numbers(numbers), .activations(activations), .find_min(find_min),
    .out_valid(out_valid), .out_ready(out_ready), .extremum(extremum),
    .extremum_index(extremum_index), .extremum_activation(extremum_activation)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [NI*NS-1:0] pack(input int a, input int b, input int c, input int d);
    logic [NS-1:0] ea, eb, ec, ed;
    ea = NS'(a); eb = NS'(b); ec = NS'(c); ed = NS'(d);
    return {ed, ec, eb, ea};
  endfunction

  // Drive a request on a negedge and return after the accepting edge (+1).
  task automatic send(input logic [NI*NS-1:0] v, input logic [NI-1:0] a, input logic fm);
    @(negedge clk);
    chk("in_ready_before_send", int'(in_ready), 1);
    numbers = v; activations = a; find_min = fm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    numbers = pack(-1, -1, -1, -1); activations = '1; find_min = ~fm;
  endtask

  // Count edges until out_valid, bounded.
  task automatic wait_done(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk(tag, n, NI);
  endtask

  task automatic expect_result(input string tag, input int ev, input int ei, input int ea);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_val"},   int'(extremum), ev);
    chk({tag, "_idx"},   int'(extremum_index), ei);
    chk({tag, "_act"},   int'(extremum_activation), ea);
  endtask

  task automatic consume(input string tag);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drop"}, int'(out_valid), 0);
    chk({tag, "_rdy"},  int'(in_ready), 1);
  endtask

  task automatic run(input string tag, input logic [NI*NS-1:0] v, input logic [NI-1:0] a,
                     input logic fm, input int ev, input int ei, input int ea);
    send(v, a, fm);
    wait_done({tag, "_lat"});
    expect_result(tag, ev, ei, ea);
    consume(tag);
  endtask

  initial begin
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_ext", int'(extremum), 0);
    chk("rst_idx", int'(extremum_index), 0);
    chk("rst_act", int'(extremum_activation), 0);
    @(negedge clk); rst_n = 1'b1;

    run("max_all",  pack(3, -2, 7, 5),   4'b1111, 1'b0, 7, 2, 1);
    run("mask_max", pack(7, -8, 7, 1),   4'b0110, 1'b0, 7, 2, 1);
    run("mask_min", pack(7, -8, 7, 1),   4'b0110, 1'b1, -8, 1, 1);
    run("tie_max",  pack(5, 5, -1, 5),   4'b1111, 1'b0, 5, 0, 1);
    run("tie_min",  pack(-8, -8, 7, -8), 4'b1011, 1'b1, -8, 0, 1);
    run("none",     pack(6, 2, -3, 4),   4'b0000, 1'b0, 0, 0, 0);

    // Back-pressure with a competing request that must be ignored.
    send(pack(-3, 6, 1, 2), 4'b1111, 1'b0);
    wait_done("bp_lat");
    expect_result("bp", 6, 1, 1);
    begin
      int bad = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        in_valid = 1'b1; numbers = pack(-8, -8, -8, -7); activations = 4'b1000; find_min = 1'b1;
        @(posedge clk); #1;
        if (!out_valid || in_ready || extremum !== 4'sd6 || extremum_index !== 2'd1
            || extremum_activation !== 1'b1) bad++;
      end
      in_valid = 1'b0;
      chk("bp_hold_bad_cycles", bad, 0);
    end
    consume("bp");
    run("after_bp", pack(-1, -5, -2, -6), 4'b1111, 1'b0, -1, 0, 1);

    // Reset two cycles into SCAN.
    send(pack(1, 2, 3, 4), 4'b1111, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_in_ready", int'(in_ready), 1);
    chk("mrst_ext", int'(extremum), 0);
    chk("mrst_idx", int'(extremum_index), 0);
    chk("mrst_act", int'(extremum_activation), 0);
    @(negedge clk); rst_n = 1'b1;
    run("post_rst", pack(1, 2, 3, 4), 4'b1111, 1'b0, 4, 3, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end
endmodule
